// File: rtl/unsharp_mask_pkg.sv
// Shared types and defaults for the unsharp-mask host buffer and its kernel wrapper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package unsharp_mask_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DUMP  = 3'd4
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DEPTH  = 1024;

  // Clocks from read enable to data on the RAM output register.
  localparam int RD_LAT = 1;

endpackage

// File: rtl/hls_bram_1p.sv
// Single-port RAM, DEPTH x DATA_W, one access per cycle, array not reset.
// Latency: read data registered, valid RD_LAT clock after re; output holds when re=0.
// Backpressure: none; the owner serialises all accesses onto the one port.
module hls_bram_1p
  import unsharp_mask_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              re,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write and registered read; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/unsharp_mask_hls_host.sv
// Host-side buffer for one kernel memory argument: load stream -> kernel ap_memory service -> dump stream.
// Latency: kernel q0 one clock after ce0&&!we0; first dump word two clocks after entering DUMP, then 1 word/clock.
// Backpressure: load_ready only in LOAD; dump side is a 2-entry skid buffer, reads issued only into free slots.
module unsharp_mask_hls_host
  import unsharp_mask_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  output logic              busy,
  output logic              done,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic [ADDR_W-1:0] mem_address0,
  input  logic              mem_ce0,
  input  logic              mem_we0,
  input  logic [DATA_W-1:0] mem_d0,
  output logic [DATA_W-1:0] mem_q0
);

  // Pointers are one bit wider than the RAM address so DEPTH itself is representable.
  localparam int PTR_W  = $clog2(DEPTH + 1);
  localparam int RAM_AW = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  END_PTR  = PTR_W'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_K  = (ADDR_W + 1)'(DEPTH);

  state_t state, state_nxt;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  // Skid buffer: entry 0 is the head presented on the dump port.
  logic [DATA_W-1:0] buf0_dat, buf1_dat;
  logic              buf0_last, buf1_last;
  logic [1:0]        buf_cnt;
  logic              rd_inflight, rd_inflight_last;

  // Kernel read-data path.
  logic              kern_rd_d, kern_oor_d;
  logic [DATA_W-1:0] q0_hold;

  logic              load_fire, kern_en, kern_in_range;
  logic              pop, issue, dump_end;
  logic [2:0]        occ_after_pop;

  logic              ram_re, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  // Handshake qualifiers and dump read-issue decision.
  always_comb begin
    load_fire     = (state == LOAD) && load_valid;
    kern_en       = ((state == START) || (state == RUN)) && mem_ce0;
    kern_in_range = ({1'b0, mem_address0} < DEPTH_K);
    pop           = (buf_cnt != 2'd0) && dump_ready;
    dump_end      = pop && buf0_last;
    // Occupancy after this cycle's pop, including the read already in flight.
    occ_after_pop = {1'b0, buf_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    issue         = (state == DUMP) && (rd_ptr < END_PTR) && (occ_after_pop < 3'd2);
  end

  // Single RAM port, owned by whichever phase is active.
  always_comb begin
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      LOAD: begin
        ram_we    = load_valid;
        ram_addr  = wr_ptr[RAM_AW-1:0];
        ram_wdata = load_data;
      end
      START, RUN: begin
        ram_we    = kern_en && mem_we0 && kern_in_range;
        ram_re    = kern_en && !mem_we0 && kern_in_range;
        ram_addr  = mem_address0[RAM_AW-1:0];
        ram_wdata = mem_d0;
      end
      DUMP: begin
        ram_re   = issue;
        ram_addr = rd_ptr[RAM_AW-1:0];
      end
      default: ;
    endcase
  end

  hls_bram_1p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; cmd_start only matters in IDLE, ap_* only in START/RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_start) state_nxt = LOAD;
      LOAD:    if (load_valid && (wr_ptr == LAST_PTR)) state_nxt = START;
      START:   if (ap_ready) state_nxt = ap_done ? DUMP : RUN;
      RUN:     if (ap_done) state_nxt = DUMP;
      DUMP:    if (dump_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy       = (state != IDLE);
    load_ready = (state == LOAD);
    ap_start   = (state == START);
  end

  // Load and dump pointers; each restarts at 0 when its phase is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if ((state == IDLE) && cmd_start) begin
        wr_ptr <= '0;
      end else if (load_fire) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if ((state != DUMP) && (state_nxt == DUMP)) begin
        rd_ptr <= '0;
      end else if (issue) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Completion pulse lands the cycle after the final dump handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == DUMP) && dump_end;
    end
  end

  // Skid buffer fill/drain; a full buffer never receives a word without a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0_dat         <= '0;
      buf1_dat         <= '0;
      buf0_last        <= 1'b0;
      buf1_last        <= 1'b0;
      buf_cnt          <= 2'd0;
      rd_inflight      <= 1'b0;
      rd_inflight_last <= 1'b0;
    end else begin
      rd_inflight      <= issue;
      rd_inflight_last <= issue && (rd_ptr == LAST_PTR);
      case (buf_cnt)
        2'd0: begin
          if (rd_inflight) begin
            buf0_dat  <= ram_rdata;
            buf0_last <= rd_inflight_last;
            buf_cnt   <= 2'd1;
          end
        end
        2'd1: begin
          if (rd_inflight && pop) begin
            buf0_dat  <= ram_rdata;
            buf0_last <= rd_inflight_last;
          end else if (rd_inflight) begin
            buf1_dat  <= ram_rdata;
            buf1_last <= rd_inflight_last;
            buf_cnt   <= 2'd2;
          end else if (pop) begin
            buf_cnt <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            buf0_dat  <= buf1_dat;
            buf0_last <= buf1_last;
            if (rd_inflight) begin
              buf1_dat  <= ram_rdata;
              buf1_last <= rd_inflight_last;
            end else begin
              buf_cnt <= 2'd1;
            end
          end
        end
        default: buf_cnt <= 2'd0;
      endcase
    end
  end

  assign dump_valid = (buf_cnt != 2'd0);
  assign dump_data  = buf0_dat;
  assign dump_last  = buf0_last && (buf_cnt != 2'd0);

  // Track kernel reads so q0 shows fresh RAM data for exactly one access, else holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kern_rd_d  <= 1'b0;
      kern_oor_d <= 1'b0;
      q0_hold    <= '0;
    end else begin
      kern_rd_d  <= kern_en && !mem_we0;
      kern_oor_d <= !kern_in_range;
      q0_hold    <= mem_q0;
    end
  end

  // Out-of-range kernel reads return zero without touching the RAM.
  assign mem_q0 = kern_rd_d ? (kern_oor_d ? '0 : ram_rdata) : q0_hold;

endmodule

// File: tb/tb_unsharp_mask_hls_host.sv
module tb_unsharp_mask_hls_host;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_start = 1'b0;
  logic          busy, done;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [DW-1:0] load_data = '0;
  logic          dump_valid;
  logic          dump_ready = 1'b0;
  logic [DW-1:0] dump_data;
  logic          dump_last;
  logic          ap_start;
  logic          ap_ready = 1'b0;
  logic          ap_done = 1'b0;
  logic [AW-1:0] mem_address0 = '0;
  logic          mem_ce0 = 1'b0;
  logic          mem_we0 = 1'b0;
  logic [DW-1:0] mem_d0 = '0;
  logic [DW-1:0] mem_q0;

  unsharp_mask_hls_host #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .busy(busy), .done(done),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data), .dump_last(dump_last),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0),
    .mem_d0(mem_d0), .mem_q0(mem_q0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: buffer contents and what q0 should currently show.
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] q0_exp = '0;

  typedef struct packed { logic [DW-1:0] d; logic l; } exp_t;
  exp_t exp_q[$];

  task automatic push_expected();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({model_mem[i], (i == DEPTH - 1)});
  endtask

  // Dump monitor / scoreboard.
  int hs_n = 0, hs_first = 0, hs_last = 0, last_hs_cyc = -10, done_cnt = 0;
  logic stall_p = 1'b0;
  logic [DW-1:0] stall_d;
  logic stall_l;
  exp_t e;

  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        check("stall_valid", dump_valid, 1);
        check("stall_data", dump_data, stall_d);
        check("stall_last", dump_last, stall_l);
      end
      stall_p = dump_valid && !dump_ready;
      stall_d = dump_data;
      stall_l = dump_last;
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dump_extra actual=0x%0h expected=no_word", dump_data);
        end else begin
          e = exp_q.pop_front();
          check("dump_data", dump_data, e.d);
          check("dump_last", dump_last, e.l);
        end
        if (hs_n == 0) hs_first = cyc;
        hs_last = cyc;
        hs_n++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_after_last_hs", cyc, last_hs_cyc + 1);
      end
    end
  end

  // Dump-ready pattern driver: 0 = always, 1 = 1,0,0,1 repeating, 2 = random.
  int rdy_mode = 0;
  int rdy_k = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       dump_ready = 1'b1;
      1:       begin dump_ready = ((rdy_k % 4) == 0) || ((rdy_k % 4) == 3); rdy_k++; end
      default: dump_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd();
    cmd_start = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    step();
    cmd_start = 1'b0;
  endtask

  task automatic load_words(input bit gaps, input bit directed);
    int n = 0;
    int t = 0;
    while (n < DEPTH && t < 200) begin
      load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      load_data  = directed ? DW'(32'h10 + n) : DW'($urandom);
      @(negedge clk);
      check("load_ready", load_ready, 1);
      if (load_valid) begin
        model_mem[n] = load_data;
        n++;
      end
      step();
      t++;
    end
    load_valid = 1'b0;
    if (n != DEPTH) begin
      checks++;
      failures++;
      $display("FAIL load_timeout actual=%0d expected=%0d", n, DEPTH);
    end
    if (!gaps) check("load_cycles", t, DEPTH);
  endtask

  task automatic start_phase(input int rdelay, input bit done_w_rdy);
    for (int k = 0; k <= rdelay; k++) begin
      ap_ready = (k == rdelay);
      ap_done  = done_w_rdy && (k == rdelay);
      if (ap_done) push_expected();
      @(negedge clk);
      check("ap_start_hold", ap_start, 1);
      step();
    end
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    @(negedge clk);
    check("ap_start_drop", ap_start, 0);
    check("busy_after_start", busy, 1);
    step();
  endtask

  task automatic kop(input bit ce, input bit we, input int addr, input logic [DW-1:0] d);
    mem_ce0 = ce;
    mem_we0 = we;
    mem_address0 = AW'(addr);
    mem_d0 = d;
    @(negedge clk);
    check("q0", mem_q0, q0_exp);
    if (ce && we && addr < DEPTH) model_mem[addr] = d;
    if (ce && !we) q0_exp = (addr < DEPTH) ? model_mem[addr] : '0;
    step();
    mem_ce0 = 1'b0;
    mem_we0 = 1'b0;
  endtask

  task automatic run_phase(input bit rnd_ops);
    if (!rnd_ops) begin
      kop(1, 0, 3, '0);
      kop(1, 1, 3, 32'hAA);
      kop(1, 0, 3, '0);
      kop(1, 0, 9, '0);
      kop(1, 1, 12, 32'h55);
      kop(0, 0, 0, '0);
      kop(0, 0, 5, '0);
    end else begin
      for (int i = 0; i < 14; i++)
        kop($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), DW'($urandom));
    end
    cmd_start = 1'b1;
    kop(0, 0, 0, '0);
    cmd_start = 1'b0;
    kop(0, 0, 0, '0);
    ap_done = 1'b1;
    push_expected();
    @(negedge clk);
    check("busy_in_run", busy, 1);
    step();
    ap_done = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int t = 0;
    while (done_cnt == base && t < 150) begin
      step();
      t++;
    end
    if (done_cnt == base) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done expected=done within 150 cycles");
    end else begin
      check("done_single", done, 0);
      check("idle_busy_after", busy, 0);
      check("dump_valid_after", dump_valid, 0);
      check("scoreboard_empty", exp_q.size(), 0);
    end
  endtask

  task automatic run_seq(input bit directed, input bit gaps, input int rdelay,
                         input bit done_w_rdy, input bit rnd_ops, input int rmode);
    int base;
    hs_n = 0;
    rdy_mode = rmode;
    base = done_cnt;
    start_cmd();
    load_words(gaps, directed);
    start_phase(rdelay, done_w_rdy);
    if (!done_w_rdy) run_phase(rnd_ops);
    wait_done(base);
  endtask

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_dump_valid", dump_valid, 0);
    check("rst_dump_last", dump_last, 0);
    check("rst_ap_start", ap_start, 0);
    check("rst_dump_data", dump_data, 0);
    check("rst_q0", mem_q0, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // Directed run: fixed data, 3-cycle ap_ready delay, scripted kernel accesses, full-rate dump.
    run_seq(1, 0, 3, 0, 0, 0);
    check("dump_count", hs_n, DEPTH);
    check("dump_throughput", hs_last - hs_first, DEPTH - 1);

    // ap_ready and ap_done together, load gaps, 1,0,0,1 dump-ready pattern.
    rdy_k = 0;
    run_seq(0, 1, 0, 1, 0, 1);
    check("dump_count2", hs_n, DEPTH);

    // Random kernel traffic and random dump backpressure.
    run_seq(0, 1, $urandom_range(0, 4), 0, 1, 2);

    // Reset in the middle of a load.
    rdy_mode = 0;
    start_cmd();
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data = DW'($urandom);
      step();
    end
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_load_ready", load_ready, 0);
    check("mid_rst_ap_start", ap_start, 0);
    check("mid_rst_dump_valid", dump_valid, 0);
    check("mid_rst_dump_last", dump_last, 0);
    check("mid_rst_dump_data", dump_data, 0);
    check("mid_rst_q0", mem_q0, 0);
    check("mid_rst_done", done, 0);
    load_valid = 1'b0;
    q0_exp = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    step();

    // Fresh full sequence after reset; must dump the newly loaded data.
    rdy_k = 0;
    run_seq(0, 0, 2, 0, 1, 1);
    check("dump_count4", hs_n, DEPTH);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unsharp_mask_hls_host.md
Name: unsharp_mask_hls_host

Overview:
- Host-side counterpart to the unsharp-mask HLS kernel. Owns the image buffer and answers the kernel's ap_memory port, drives the kernel's ap_ctrl_hs handshake, and moves data with the host over valid/ready streams.
- One command runs the sequence: stream in DEPTH words, start the kernel and serve its memory accesses, wait for completion, then stream DEPTH words back out.
- Instantiated once per kernel memory argument that the host must load and dump (img, mask_img).

Parameters:
- DATA_W, 32: word width; matches kernel d0/q0.
- ADDR_W, 10: kernel address width.
- DEPTH, 1024: buffer words; must satisfy 2 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_start  in  1  one-cycle request to run the full sequence.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last dump word is accepted.
- load_valid  in  1  host load stream valid.
- load_ready  out  1  load stream ready.
- load_data  in  DATA_W  load word.
- dump_valid  out  1  host dump stream valid.
- dump_ready  in  1  dump stream ready.
- dump_data  out  DATA_W  dump word.
- dump_last  out  1  marks word DEPTH-1.
- ap_start  out  1  kernel start.
- ap_ready  in  1  kernel accepted start.
- ap_done  in  1  kernel finished.
- mem_address0  in  ADDR_W  kernel address.
- mem_ce0  in  1  kernel chip enable.
- mem_we0  in  1  kernel write enable.
- mem_d0  in  DATA_W  kernel write data.
- mem_q0  out  DATA_W  kernel read data.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, pointers=0, skid buffer emptied. All outputs 0 (busy, done, load_ready, dump_valid, dump_last, ap_start, dump_data, mem_q0). RAM contents are not cleared.
- IDLE:
  - cmd_start=1 -> LOAD with wr_ptr=0.
  - cmd_start is ignored in every other state.
- LOAD:
  - load_ready=1.
  - Each load_valid&&load_ready cycle writes mem[wr_ptr] and increments wr_ptr.
  - The handshake at wr_ptr==DEPTH-1 -> START.
- START:
  - ap_start=1 from the first START cycle, held until the cycle ap_ready=1 is sampled.
  - ap_start drops the next cycle, and the block moves to RUN.
  - If ap_done=1 in the same cycle as ap_ready, go straight to DUMP.
- RUN: ap_start=0; ap_done=1 -> DUMP with rd_ptr=0. ap_ready and ap_done are ignored outside START and RUN.
- Kernel memory port (serviced only in START and RUN):
  - ce0&&we0: write mem[address0]=d0; q0 holds its previous value.
  - ce0&&!we0: q0 = mem[address0] on the next clock edge (1-cycle latency).
  - ce0=0: q0 holds.
  - address0 >= DEPTH: writes dropped, reads return 0.
  - In all other states the kernel port is ignored and q0 holds.
- DUMP:
  - rd_ptr issues RAM reads into a 2-entry skid buffer.
  - A read is issued only while the buffer has a free slot, counting the read in flight.
  - dump_valid=1 whenever the buffer is non-empty.
  - Sustains 1 word/cycle while dump_ready=1.
  - Words appear in address order 0..DEPTH-1; dump_last=1 only with word DEPTH-1.
  - dump_data and dump_last are stable while dump_valid&&!dump_ready.
  - The last handshake -> IDLE, with done=1 for one cycle on the cycle after that handshake.
- RAM: single physical port, muxed by state (LOAD: host write; START/RUN: kernel; DUMP: read pointer). Phases are exclusive, so there is no arbitration.
- Pointer widths: $clog2(DEPTH+1) bits, so the compare against DEPTH-1 never wraps.

Decomposition:
- Package unsharp_mask_pkg holds:
  - the state enum (IDLE, LOAD, START, RUN, DUMP);
  - the default DATA_W / ADDR_W / DEPTH constants shared with the kernel wrapper;
  - a read-latency constant (1).
- Sub-module hls_bram_1p: single-port RAM, DEPTH x DATA_W, registered read output, read-enable and write-enable inputs, no reset on the array.
- The FSM, port mux and skid buffer live in the top.

Test Plan:
- DEPTH=8, cmd_start, load 0x10..0x17 with load_valid held high -> 8 accepts in 8 cycles, then ap_start rises.
- Kernel model holds ap_ready=0 for 3 cycles -> ap_start stays 1 for exactly 4 cycles and drops the cycle after ap_ready.
- In RUN, kernel reads addr 3 then writes 0xAA to addr 3, then reads addr 3 -> q0=0x13 one cycle after the first read; q0 unchanged during the write; q0=0xAA after the second read. Read of addr 9 (>= DEPTH) -> q0=0.
- ap_done, then dump with dump_ready=1 -> 8 words 0x10,0x11,0x12,0xAA,0x14..0x17 on consecutive cycles, dump_last only on the 8th, done pulse the next cycle.
- Dump with dump_ready toggling 1,0,0,1 repeating -> no word lost or duplicated, dump_data stable while stalled, order preserved.
- Assert rst mid-LOAD after 4 words, then re-run a full sequence -> outputs 0 immediately, busy=0, cmd_start ignored while busy; new run dumps the newly loaded data.
